// File: rtl/fetch_pc_ctrl_pkg.sv
// Shared types and constants for the RV32I fetch sequencer.
package fetch_pc_ctrl_pkg;

  typedef enum logic [1:0] {BOOT, REQ, WAIT, FULL} fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_INC    = 32'd4;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/fetch_pc_ctrl_if.sv
// Single-outstanding req/gnt/rvalid instruction-memory port.
interface fetch_pc_ctrl_if;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/fetch_pc_ctrl_pc_next_sel.sv
// Next fetch address: trap vector beats branch target beats sequential pc+4.
module fetch_pc_ctrl_pc_next_sel
  import fetch_pc_ctrl_pkg::*;
(
  input  logic        trap,
  input  logic [31:0] trap_target,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic [31:0] pc,
  output logic [31:0] next_pc
);

  always_comb begin
    if (trap)          next_pc = word_align(trap_target);
    else if (br_taken) next_pc = word_align(br_target);
    else               next_pc = pc + PC_INC;
  end

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Fetch sequencer: owns the fetch PC, talks to instruction memory, fills the IF/ID slot.
//  state | meaning
//  BOOT  | idle for one cycle after reset release
//  REQ   | request pending on the memory port
//  WAIT  | granted, waiting for rvalid
//  FULL  | response parked in hold buffer while IF/ID is stalled
module fetch_pc_ctrl
  import fetch_pc_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR    = fetch_pc_ctrl_pkg::NOP_INSTR
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall_i,
  input  logic                   br_taken_i,
  input  logic [31:0]            br_target_i,
  input  logic                   trap_i,
  input  logic [31:0]            trap_target_i,
  fetch_pc_ctrl_if.master        imem,
  output logic                   if_valid_o,
  output logic [31:0]            if_pc_o,
  output logic [31:0]            if_instr_o
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d, sel_pc;
  logic         drop_q, drop_d;
  logic         hold_vld_q, hold_vld_d;
  logic [31:0]  hold_pc_q, hold_pc_d, hold_instr_q, hold_instr_d;
  logic         req_q, req_d;
  logic [31:0]  addr_q, addr_d;
  logic         valid_q, valid_d;
  logic [31:0]  ifpc_q, ifpc_d, instr_q, instr_d;
  logic         redirect;

  assign redirect = trap_i | br_taken_i;

  fetch_pc_ctrl_pc_next_sel u_pc_next_sel (
    .trap        (trap_i),
    .trap_target (trap_target_i),
    .br_taken    (br_taken_i),
    .br_target   (br_target_i),
    .pc          (pc_q),
    .next_pc     (sel_pc)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drop_d       = drop_q;
    hold_vld_d   = hold_vld_q;
    hold_pc_d    = hold_pc_q;
    hold_instr_d = hold_instr_q;
    valid_d      = valid_q;
    ifpc_d       = ifpc_q;
    instr_d      = instr_q;
    if (!stall_i) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end
    case (state_q)
      BOOT: begin
        state_d = REQ;
        pc_d    = RESET_VECTOR;
      end
      REQ: begin
        if (imem.gnt) begin
          state_d = WAIT;
          pc_d    = sel_pc;
          drop_d  = redirect;
        end else if (redirect) begin
          pc_d = sel_pc;
        end
      end
      WAIT: begin
        if (redirect) pc_d = sel_pc;
        if (imem.rvalid) begin
          state_d = REQ;
          drop_d  = 1'b0;
          if (!drop_q && !redirect) begin
            if (!valid_q || !stall_i) begin
              valid_d = 1'b1;
              ifpc_d  = addr_q;
              instr_d = imem.rdata;
            end else begin
              hold_vld_d   = 1'b1;
              hold_pc_d    = addr_q;
              hold_instr_d = imem.rdata;
              state_d      = FULL;
            end
          end
        end else if (redirect) begin
          drop_d = 1'b1;
        end
      end
      FULL: begin
        if (redirect) begin
          state_d = REQ;
          pc_d    = sel_pc;
        end else if (!stall_i && hold_vld_q) begin
          valid_d    = 1'b1;
          ifpc_d     = hold_pc_q;
          instr_d    = hold_instr_q;
          hold_vld_d = 1'b0;
          state_d    = REQ;
        end
      end
      default: state_d = BOOT;
    endcase
    // A redirect flushes the slot even under stall.
    if (redirect && state_q != BOOT) begin
      valid_d    = 1'b0;
      instr_d    = NOP_INSTR;
      hold_vld_d = 1'b0;
    end
    req_d  = (state_d == REQ);
    addr_d = (state_d == REQ) ? pc_d : addr_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= BOOT;
      pc_q         <= RESET_VECTOR;
      drop_q       <= 1'b0;
      hold_vld_q   <= 1'b0;
      hold_pc_q    <= '0;
      hold_instr_q <= NOP_INSTR;
      req_q        <= 1'b0;
      addr_q       <= RESET_VECTOR;
      valid_q      <= 1'b0;
      ifpc_q       <= '0;
      instr_q      <= NOP_INSTR;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drop_q       <= drop_d;
      hold_vld_q   <= hold_vld_d;
      hold_pc_q    <= hold_pc_d;
      hold_instr_q <= hold_instr_d;
      req_q        <= req_d;
      addr_q       <= addr_d;
      valid_q      <= valid_d;
      ifpc_q       <= ifpc_d;
      instr_q      <= instr_d;
    end
  end

  assign imem.req   = req_q;
  assign imem.addr  = addr_q;
  assign if_valid_o = valid_q;
  assign if_pc_o    = ifpc_q;
  assign if_instr_o = instr_q;

endmodule
